buffer_pixeles_mem_fifo: RTL
============================

// Module: buffer_pixeles_mem_fifo
// PURPOSE
//   Parametrised successor to the single-word pixel buffer. Stores DEPTH memory words of MEM_W bits
//   and unpacks them into PIX_W-bit pixels for the filter pipeline. Pixels leave in a configurable
//   order. Sits between the memory read port and the filter window/line-buffer stage.
// PARAMETERS
//   MEM_W      32  memory word width; must be an integer multiple of PIX_W
//   PIX_W       8  pixel width
//   DEPTH       4  word FIFO depth; power of two, >=2
//   MSB_FIRST   1  1: first pixel = word[MEM_W-1 -: PIX_W]; 0: first pixel = word[PIX_W-1:0]
// PORTS
//   clk              in   1          rising-edge clock
//   reset            in   1          synchronous, active-high
//   memory_data      in   MEM_W      word from memory
//   save_mem_data    in   1          write strobe; accepted only when space_available=1
//   read_pixel       in   1          pixel consume strobe; accepted only when data_available=1
//   pixel            out  PIX_W      current head pixel (show-ahead); 0 when data_available=0
//   space_available  out  1          at least one free word slot
//   data_available   out  1          at least one unread pixel
//   overflow         out  1          sticky: save_mem_data seen while space_available=0
//   underflow        out  1          sticky: read_pixel seen while data_available=0
//   level            out  clog2(DEPTH)+1  stored words, incl. partially read head (PIXBUF_LEVEL_EN only)
// BEHAVIOUR
//   - Reset: all pointers, word count and slice index are cleared. pixel=0, data_available=0,
//     space_available=1, overflow=0, underflow=0, level=0. Reset mid-stream discards all content.
//   - PPW = MEM_W/PIX_W pixels per word. A slice index 0..PPW-1 selects the head-word pixel.
//   - Write: save_mem_data & space_available stores memory_data at the tail on the edge.
//     The word is visible on pixel/data_available on the next cycle, so latency is 1.
//   - Read: read_pixel & data_available advances the slice index. At PPW-1 the index wraps to 0
//     and the head word is popped. The next pixel appears in the cycle after the edge.
//   - space_available = (count < DEPTH); data_available = (count != 0). Both are derived from
//     registered count only, not from same-cycle strobes.
//   - Simultaneous write and pop: count is unchanged. When full, the write is rejected even if a
//     pop happens in the same cycle, and overflow is set. The pop still completes.
//   - Read when empty: ignored, state is unchanged, underflow is set.
//   - Write when full: ignored, data is dropped, overflow is set. Sticky flags clear only on reset.
//   - Pointers wrap modulo DEPTH. The count saturates 0..DEPTH by construction.
//   - pixel is a mux of head-word storage by slice index. No combinational path exists from
//     save_mem_data or read_pixel to any output.
// CONFIGURATION
//   PIXBUF_LEVEL_EN defined: the level port exists and equals the registered count; also fixes
//     the port list.
//   PIXBUF_LEVEL_EN undefined: the level port is absent. The count is internal only.
//     All other behaviour is identical.
// STRUCTURE
//   - pixbuf_pkg holds: function clog2, localparam helpers for PPW/slice width, ordering constants
//     ORDER_MSB/ORDER_LSB.
//   - Sub-module pixbuf_word_fifo holds the DEPTH x MEM_W storage, wr/rd pointers and count, and
//     exposes full/empty/head word.
//   - The top level adds the slice counter, order mux, pop generation and sticky flags.
// TESTING
//   1 reset, then idle -> pixel=0, data_available=0, space_available=1, overflow=underflow=0.
//   2 MSB_FIRST=1, write 0xAABBCCDD, then read 4x back-to-back -> pixel AA,BB,CC,DD;
//     data_available falls after 4th read.
//   3 MSB_FIRST=0, write 0xAABBCCDD -> pixel DD,CC,BB,AA.
//   4 write 0xABCDEF77, 0x12345678, 0x87654321, 0x11223344 -> space_available=0; 5th write
//     0xDEADBEEF -> overflow=1; read 16 -> stream ends 0x44, no DEADBEEF bytes.
//   5 full FIFO, 4th read of head word coincident with write 0x55667788 -> write dropped,
//     overflow=1, count 3; if not full -> accepted, count unchanged.
//   6 read_pixel while empty -> underflow=1, pixel stays 0; assert reset mid-word after 2 reads ->
//     next written 0x01020304 yields 01 first.

Source files
------------

// File: rtl/pixbuf_pkg.sv
// Shared helpers for the pixel buffer: clog2, pixels-per-word and slice-index width
// helpers, and the pixel ordering constants.
package pixbuf_pkg;

  localparam int unsigned ORDER_LSB = 0;
  localparam int unsigned ORDER_MSB = 1;

  // Ceiling log2. Returns 0 for v <= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned calc_ppw(input int unsigned mem_w, input int unsigned pix_w);
    return mem_w / pix_w;
  endfunction

  // Slice index needs at least one bit even when a word holds a single pixel.
  function automatic int unsigned calc_slice_w(input int unsigned ppw);
    return (ppw > 1) ? clog2(ppw) : 1;
  endfunction

endpackage

// File: rtl/pixbuf_word_fifo.sv
// Word FIFO for the pixel buffer: Depth x MemW storage, wrap-around pointers and an
// occupancy count. Head word is show-ahead.
// Ports:
//   clk_i    clock; rst_i synchronous active-high reset
//   push_i   store wdata_i at the tail (ignored when full)
//   pop_i    drop the head word (ignored when empty)
//   head_o   word at the read pointer
//   full_o / empty_o / count_o  registered occupancy
module pixbuf_word_fifo
  import pixbuf_pkg::*;
#(
  parameter int unsigned MemW  = 32,
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [MemW-1:0] wdata_i,
  output logic [MemW-1:0] head_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [CntW-1:0] count_o
);

  logic [MemW-1:0] mem_q [Depth];
  logic [MemW-1:0] mem_d [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            push_ok, pop_ok;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Full rejects a push even when a pop happens in the same cycle.
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    mem_d = mem_q;
    if (push_ok) mem_d[wr_ptr_q] = wdata_i;
    // Depth is a power of two, so pointers wrap by natural overflow.
    wr_ptr_d = wr_ptr_q + PtrW'(push_ok);
    rd_ptr_d = rd_ptr_q + PtrW'(pop_ok);
    count_d  = count_q + CntW'(push_ok) - CntW'(pop_ok);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; content is only visible through the count.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/buffer_pixeles_mem_fifo.sv
// Pixel buffer: queues DEPTH memory words and unpacks each into MEM_W/PIX_W pixels,
// first pixel taken from the MSB or LSB end depending on MSB_FIRST.
// Ports:
//   clk, reset (synchronous, active-high)
//   memory_data / save_mem_data   word input and write strobe
//   read_pixel                    consume the current pixel
//   pixel                         show-ahead head pixel, 0 when nothing is stored
//   space_available / data_available  registered occupancy status
//   overflow / underflow          sticky misuse flags, cleared only by reset
//   level                         stored word count; present only with PIXBUF_LEVEL_EN defined
module buffer_pixeles_mem_fifo
  import pixbuf_pkg::*;
#(
  parameter int unsigned MEM_W     = 32,
  parameter int unsigned PIX_W     = 8,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned MSB_FIRST = 1,
  localparam int unsigned CntW     = clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [MEM_W-1:0] memory_data,
  input  logic             save_mem_data,
  input  logic             read_pixel,
  output logic [PIX_W-1:0] pixel,
  output logic             space_available,
  output logic             data_available,
  output logic             overflow,
  output logic             underflow
`ifdef PIXBUF_LEVEL_EN
  ,
  output logic [CntW-1:0]  level
`endif
);

  localparam int unsigned Ppw    = calc_ppw(MEM_W, PIX_W);
  localparam int unsigned SliceW = calc_slice_w(Ppw);

  logic             full, empty;
  logic [MEM_W-1:0] head;
  logic [CntW-1:0]  count;
  logic             rd_ok, last_slice, pop;
  logic [SliceW-1:0] slice_q, slice_d, sel;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic [PIX_W-1:0] pix_arr [Ppw];

  pixbuf_word_fifo #(
    .MemW  (MEM_W),
    .Depth (DEPTH)
  ) u_word_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .push_i  (save_mem_data),
    .pop_i   (pop),
    .wdata_i (memory_data),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  assign rd_ok      = read_pixel & ~empty;
  assign last_slice = (slice_q == SliceW'(Ppw - 1));
  assign pop        = rd_ok & last_slice;

  always_comb begin
    slice_d = slice_q;
    if (rd_ok) slice_d = last_slice ? '0 : slice_q + SliceW'(1);
    overflow_d  = overflow_q | (save_mem_data & full);
    underflow_d = underflow_q | (read_pixel & empty);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slice_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      slice_q     <= slice_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // pix_arr[i] is the pixel at bit offset i*PIX_W; ordering only changes which one is selected.
  always_comb begin
    for (int i = 0; i < int'(Ppw); i++) begin
      pix_arr[i] = head[i*PIX_W +: PIX_W];
    end
  end

  assign sel = (MSB_FIRST == ORDER_MSB) ? SliceW'(Ppw - 1) - slice_q : slice_q;

  assign pixel           = empty ? '0 : pix_arr[sel];
  assign data_available  = ~empty;
  assign space_available = ~full;
  assign overflow        = overflow_q;
  assign underflow       = underflow_q;

`ifdef PIXBUF_LEVEL_EN
  assign level = count;
`else
  logic unused_count;
  assign unused_count = ^count;
`endif

endmodule
